// File: rtl/cp0_regs_if.sv
// CP0 register-file port bundle: MTC0/MFC0 access, exception/ERET commit, interrupt lines.
// master = pipeline side driving requests, slave = cp0_regs.
interface cp0_regs_if;
    logic        c0_we;
    logic [7:0]  c0_addr;
    logic [31:0] c0_wdata;
    logic [31:0] c0_rdata;
    logic        ex_valid;
    logic [4:0]  ex_code;
    logic        ex_bd;
    logic [31:0] ex_pc;
    logic [31:0] ex_badvaddr;
    logic        eret_flush;
    logic [5:0]  ext_int;
    logic [31:0] epc;
    logic        int_req;

    modport master (
        output c0_we, c0_addr, c0_wdata, ex_valid, ex_code, ex_bd, ex_pc,
               ex_badvaddr, eret_flush, ext_int,
        input  c0_rdata, epc, int_req
    );

    modport slave (
        input  c0_we, c0_addr, c0_wdata, ex_valid, ex_code, ex_bd, ex_pc,
               ex_badvaddr, eret_flush, ext_int,
        output c0_rdata, epc, int_req
    );
endinterface

// File: rtl/cp0_regs.sv
// MIPS CP0 subset: BadVAddr, Status, Cause, EPC, plus Count/Compare timer when CP0_TIMER_EN is defined.
// Reads are combinational; writes and exception updates land on the next clk edge, no handshake/backpressure.
module cp0_regs (
    input  logic     clk,
    input  logic     reset,
    cp0_regs_if.slave bus
);
    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;

    logic        w_ti;
    logic        w_ti_next;
    logic        w_badv_load;
    logic [31:0] w_status;
    logic [31:0] w_cause;

`ifdef CP0_TIMER_EN
    localparam logic [7:0] ADDR_COUNT   = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE = {5'd11, 3'd0};

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_tick;
    logic        r_ti;
    logic        w_count_wr;
    logic        w_compare_wr;

    // Timer writes are not subject to the exception/ERET priority chain.
    assign w_count_wr   = bus.c0_we && (bus.c0_addr == ADDR_COUNT);
    assign w_compare_wr = bus.c0_we && (bus.c0_addr == ADDR_COMPARE);

    always_comb begin
        w_ti_next = r_ti;
        if (w_compare_wr)
            w_ti_next = 1'b0;
        else if (r_count == r_compare)
            w_ti_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_tick    <= 1'b0;
            r_ti      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            r_ti   <= w_ti_next;
            if (w_count_wr)
                r_count <= bus.c0_wdata;
            else if (r_tick)
                r_count <= r_count + 32'd1;
            if (w_compare_wr)
                r_compare <= bus.c0_wdata;
        end
    end

    assign w_ti = r_ti;
`else
    assign w_ti      = 1'b0;
    assign w_ti_next = 1'b0;
`endif

    assign w_badv_load = bus.ex_valid && (bus.ex_code >= 5'd1) && (bus.ex_code <= 5'd5);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_badvaddr <= 32'd0;
            r_epc      <= 32'd0;
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip_hw    <= 6'd0;
            r_ip_sw    <= 2'd0;
            r_exccode  <= 5'd0;
        end else begin
            // IP[15] folds in the post-edge TI so a Compare write drops int_req one cycle later.
            r_ip_hw <= {bus.ext_int[5] | w_ti_next, bus.ext_int[4:0]};
            if (bus.ex_valid) begin
                r_exl     <= 1'b1;
                r_exccode <= bus.ex_code;
                if (!r_exl) begin
                    r_epc <= bus.ex_bd ? (bus.ex_pc - 32'd4) : bus.ex_pc;
                    r_bd  <= bus.ex_bd;
                end
                if (w_badv_load)
                    r_badvaddr <= bus.ex_badvaddr;
            end else if (bus.eret_flush) begin
                r_exl <= 1'b0;
            end else if (bus.c0_we) begin
                case (bus.c0_addr)
                    ADDR_STATUS: begin
                        r_im  <= bus.c0_wdata[15:8];
                        r_exl <= bus.c0_wdata[1];
                        r_ie  <= bus.c0_wdata[0];
                    end
                    ADDR_CAUSE: r_ip_sw <= bus.c0_wdata[9:8];
                    ADDR_EPC:   r_epc   <= bus.c0_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
    assign w_cause  = {r_bd, w_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'd0};

    always_comb begin
        bus.c0_rdata = 32'd0;
        case (bus.c0_addr)
            ADDR_BADVADDR: bus.c0_rdata = r_badvaddr;
            ADDR_STATUS:   bus.c0_rdata = w_status;
            ADDR_CAUSE:    bus.c0_rdata = w_cause;
            ADDR_EPC:      bus.c0_rdata = r_epc;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:    bus.c0_rdata = r_count;
            ADDR_COMPARE:  bus.c0_rdata = r_compare;
`endif
            default:       bus.c0_rdata = 32'd0;
        endcase
    end

    assign bus.epc     = r_epc;
    assign bus.int_req = (|({r_ip_hw, r_ip_sw} & r_im)) & r_ie & ~r_exl & ~reset;
endmodule

// File: tb/tb_cp0_regs.sv
// Directed self-checking bench for cp0_regs; covers both CP0_TIMER_EN builds.
module tb_cp0_regs;
    localparam logic [7:0] A_BADV  = 8'h40;
    localparam logic [7:0] A_COUNT = 8'h48;
    localparam logic [7:0] A_CMP   = 8'h58;
    localparam logic [7:0] A_STAT  = 8'h60;
    localparam logic [7:0] A_CAUSE = 8'h68;
    localparam logic [7:0] A_EPC   = 8'h70;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    cp0_regs_if bus ();
    cp0_regs dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
        bus.c0_we = 1'b1; bus.c0_addr = addr; bus.c0_wdata = data;
        step();
        bus.c0_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        bus.c0_addr = addr;
        #1;
        check_eq(tag, bus.c0_rdata, exp);
    endtask

    task automatic raise_ex(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                            input logic [31:0] badv);
        bus.ex_valid = 1'b1; bus.ex_code = code; bus.ex_bd = bd;
        bus.ex_pc = pc; bus.ex_badvaddr = badv;
        step();
        bus.ex_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.c0_we = 1'b0; bus.c0_addr = 8'h0; bus.c0_wdata = 32'h0;
        bus.ex_valid = 1'b0; bus.ex_code = 5'd0; bus.ex_bd = 1'b0;
        bus.ex_pc = 32'h0; bus.ex_badvaddr = 32'h0;
        bus.eret_flush = 1'b0; bus.ext_int = 6'd0;
        repeat (2) step();

        check_eq("rst_int_req", {31'd0, bus.int_req}, 32'h0);
        rd_chk("rst_status", A_STAT, 32'h0040_0000);
        rd_chk("rst_epc", A_EPC, 32'h0);
        rd_chk("rst_cause", A_CAUSE, 32'h0);
        check_eq("rst_epc_port", bus.epc, 32'h0);
        reset = 1'b0;
        #1;
        check_eq("post_rst_int_req", {31'd0, bus.int_req}, 32'h0);
        step();

`ifdef CP0_TIMER_EN
        begin
            bit got = 1'b0;
            int cyc = 0;
            mtc0(A_CMP, 32'd5);
            mtc0(A_COUNT, 32'd0);
            bus.c0_addr = A_CAUSE;
            for (int i = 0; i < 40 && !got; i++) begin
                step();
                cyc++;
                got = bus.c0_rdata[30];
            end
            check_eq("ti_set", {31'd0, got}, 32'h1);
            check_eq("ti_latency", {31'd0, (cyc >= 8 && cyc <= 14)}, 32'h1);
            mtc0(A_STAT, 32'h0040_8001);
            check_eq("timer_int_req", {31'd0, bus.int_req}, 32'h1);
            mtc0(A_CMP, 32'hFFFF_0000);
            check_eq("cmp_wr_drop_int", {31'd0, bus.int_req}, 32'h0);
            rd_chk("cmp_wr_clr_ti", A_CAUSE, 32'h0);
            mtc0(A_COUNT, 32'd100);
            repeat (4) step();
            rd_chk("count_half_rate", A_COUNT, 32'd102);
        end
`else
        mtc0(A_COUNT, 32'h1234);
        rd_chk("count_absent", A_COUNT, 32'h0);
        mtc0(A_CMP, 32'h5);
        rd_chk("compare_absent", A_CMP, 32'h0);
        bus.ext_int = 6'b100000;
        step();
        rd_chk("ip15_ext_only", A_CAUSE, 32'h0000_8000);
        bus.ext_int = 6'd0;
        step();
`endif
        mtc0(A_STAT, 32'h0040_8001);

        raise_ex(5'd4, 1'b1, 32'hBFC0_0104, 32'h1);
        check_eq("ex1_epc_port", bus.epc, 32'hBFC0_0100);
        rd_chk("ex1_cause", A_CAUSE, 32'h8000_0010);
        rd_chk("ex1_badv", A_BADV, 32'h1);
        rd_chk("ex1_status_exl", A_STAT, 32'h0040_8003);

        raise_ex(5'd8, 1'b0, 32'h8000_0000, 32'h55);
        rd_chk("ex2_epc_kept", A_EPC, 32'hBFC0_0100);
        rd_chk("ex2_cause", A_CAUSE, 32'h8000_0020);
        rd_chk("ex2_badv_kept", A_BADV, 32'h1);

        bus.ex_valid = 1'b1; bus.ex_code = 5'd0; bus.ex_bd = 1'b0; bus.ex_pc = 32'h1000;
        bus.eret_flush = 1'b1;
        bus.c0_we = 1'b1; bus.c0_addr = A_STAT; bus.c0_wdata = 32'h0;
        step();
        bus.ex_valid = 1'b0; bus.eret_flush = 1'b0; bus.c0_we = 1'b0;
        rd_chk("prio_status", A_STAT, 32'h0040_8003);
        rd_chk("prio_cause", A_CAUSE, 32'h8000_0000);

        bus.eret_flush = 1'b1;
        step();
        bus.eret_flush = 1'b0;
        rd_chk("eret_clr_exl", A_STAT, 32'h0040_8001);

        bus.c0_we = 1'b1; bus.c0_addr = A_STAT; bus.c0_wdata = 32'h0040_0401;
        #1;
        check_eq("no_bypass", bus.c0_rdata, 32'h0040_8001);
        step();
        bus.c0_we = 1'b0;
        rd_chk("mtc0_visible", A_STAT, 32'h0040_0401);

        bus.ext_int = 6'b000001;
        step();
        check_eq("ext_int_req", {31'd0, bus.int_req}, 32'h1);
        rd_chk("ext_cause", A_CAUSE, 32'h8000_0400);

        mtc0(A_CAUSE, 32'hFFFF_FFFF);
        rd_chk("cause_sw_ip", A_CAUSE, 32'h8000_0700);
        mtc0(A_BADV, 32'h1234);
        rd_chk("badv_ro", A_BADV, 32'h1);
        rd_chk("unimpl_0", 8'h00, 32'h0);
        rd_chk("unimpl_sel1", 8'h61, 32'h0);
        mtc0(A_EPC, 32'h1234_5678);
        check_eq("epc_wr", bus.epc, 32'h1234_5678);

        raise_ex(5'd2, 1'b0, 32'h0040_0020, 32'hDEAD_0000);
        check_eq("ex3_epc", bus.epc, 32'h0040_0020);
        rd_chk("ex3_badv", A_BADV, 32'hDEAD_0000);
        rd_chk("ex3_cause", A_CAUSE, 32'h0000_0708);
        check_eq("ex3_int_masked", {31'd0, bus.int_req}, 32'h0);

        bus.eret_flush = 1'b1;
        step();
        bus.eret_flush = 1'b0;
        check_eq("pre_rst_int_req", {31'd0, bus.int_req}, 32'h1);

        reset = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_code = 5'd4; bus.ex_badvaddr = 32'hFFFF_FFFF;
        bus.c0_we = 1'b1; bus.c0_addr = A_STAT; bus.c0_wdata = 32'hFFFF_FFFF;
        #1;
        check_eq("rst_gate_int_req", {31'd0, bus.int_req}, 32'h0);
        step();
        bus.ex_valid = 1'b0; bus.c0_we = 1'b0; bus.ext_int = 6'd0;
        rd_chk("mid_rst_status", A_STAT, 32'h0040_0000);
        rd_chk("mid_rst_cause", A_CAUSE, 32'h0);
        rd_chk("mid_rst_epc", A_EPC, 32'h0);
        rd_chk("mid_rst_badv", A_BADV, 32'h0);
        reset = 1'b0;
        step();
        check_eq("post_rst2_int_req", {31'd0, bus.int_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
